// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard resolver: forwarding-select codes,
// memory wait-state encoding and the default register-address width.
package hazard_unit_pkg;

  localparam int RW_DEF = 4;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // The M-stage result is younger than the W-stage result, so it wins.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (hit_m)      sel = FWD_M;
    else if (hit_w) sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_regpipe.sv
// Shadow pipeline of register addresses (D->E->M->W) with per-stage valid bits,
// so forwarding compares use addresses staged alongside the real datapath.
module hazard_regpipe
  import hazard_unit_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] ra1_d_i,
  input  logic [RW-1:0] ra2_d_i,
  input  logic [RW-1:0] wa3_d_i,
  input  logic          stall_e_i,
  input  logic          flush_e_i,
  input  logic          stall_m_i,
  input  logic          flush_w_i,
  output logic [RW-1:0] ra1_e_o,
  output logic [RW-1:0] ra2_e_o,
  output logic [RW-1:0] wa3_e_o,
  output logic          valid_e_o,
  output logic [RW-1:0] wa3_m_o,
  output logic          valid_m_o,
  output logic [RW-1:0] wa3_w_o,
  output logic          valid_w_o
);

  logic [RW-1:0] ra1_e_q, ra1_e_d;
  logic [RW-1:0] ra2_e_q, ra2_e_d;
  logic [RW-1:0] wa3_e_q, wa3_e_d;
  logic          valid_e_q, valid_e_d;
  logic [RW-1:0] wa3_m_q, wa3_m_d;
  logic          valid_m_q, valid_m_d;
  logic [RW-1:0] wa3_w_q, wa3_w_d;
  logic          valid_w_q, valid_w_d;

  // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
  always_comb begin
    ra1_e_d   = ra1_e_q;
    ra2_e_d   = ra2_e_q;
    wa3_e_d   = wa3_e_q;
    valid_e_d = valid_e_q;
    wa3_m_d   = wa3_m_q;
    valid_m_d = valid_m_q;
    if (!stall_e_i) begin
      ra1_e_d   = ra1_d_i;
      ra2_e_d   = ra2_d_i;
      wa3_e_d   = wa3_d_i;
      valid_e_d = !flush_e_i;
    end
    if (!stall_m_i) begin
      wa3_m_d   = wa3_e_q;
      valid_m_d = valid_e_q;
    end
    // W never holds; a frozen M stage hands W a bubble instead of a duplicate.
    wa3_w_d   = wa3_m_q;
    valid_w_d = valid_m_q & !flush_w_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1_e_q   <= '0;
      ra2_e_q   <= '0;
      wa3_e_q   <= '0;
      valid_e_q <= 1'b0;
      wa3_m_q   <= '0;
      valid_m_q <= 1'b0;
      wa3_w_q   <= '0;
      valid_w_q <= 1'b0;
    end else begin
      ra1_e_q   <= ra1_e_d;
      ra2_e_q   <= ra2_e_d;
      wa3_e_q   <= wa3_e_d;
      valid_e_q <= valid_e_d;
      wa3_m_q   <= wa3_m_d;
      valid_m_q <= valid_m_d;
      wa3_w_q   <= wa3_w_d;
      valid_w_q <= valid_w_d;
    end
  end

  assign ra1_e_o   = ra1_e_q;
  assign ra2_e_o   = ra2_e_q;
  assign wa3_e_o   = wa3_e_q;
  assign valid_e_o = valid_e_q;
  assign wa3_m_o   = wa3_m_q;
  assign valid_m_o = valid_m_q;
  assign wa3_w_o   = wa3_w_q;
  assign valid_w_o = valid_w_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard resolver for the 5-stage core: forwarding selects, load-use and PC-write
// stalls, branch flushes, and a data-memory wait-state FSM with sticky timeout.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int RW         = RW_DEF,
  parameter int WAIT_LIMIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] RA1D,
  input  logic [RW-1:0] RA2D,
  input  logic [RW-1:0] WA3D,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          PCSrcD,
  input  logic          PCSrcE,
  input  logic          PCSrcM,
  input  logic          PCSrcW,
  input  logic          BranchTakenE,
  input  logic          MemReqM,
  input  logic          MemReadyM,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          StallM,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushW,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          MemTimeout
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [RW-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic          valid_e, valid_m, valid_w;

  mem_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
  logic          abort_q;

  logic mem_stall, ldr_stall, pc_wr_pend;
  logic flush_e_int;

  hazard_regpipe #(.RW(RW)) u_regpipe (
    .clk       (clk),
    .reset     (reset),
    .ra1_d_i   (RA1D),
    .ra2_d_i   (RA2D),
    .wa3_d_i   (WA3D),
    .stall_e_i (mem_stall),
    .flush_e_i (flush_e_int),
    .stall_m_i (mem_stall),
    .flush_w_i (mem_stall),
    .ra1_e_o   (ra1_e),
    .ra2_e_o   (ra2_e),
    .wa3_e_o   (wa3_e),
    .valid_e_o (valid_e),
    .wa3_m_o   (wa3_m),
    .valid_m_o (valid_m),
    .wa3_w_o   (wa3_w),
    .valid_w_o (valid_w)
  );

  // abort_q marks the cycle after a timeout, when the abandoned request must not re-arm the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MEM_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        MEM_IDLE: begin
          if (MemReqM && !MemReadyM && !abort_q) begin
            state_q <= MEM_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(WAIT_LIMIT)) begin
            state_q   <= MEM_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            abort_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // A ready in WAIT completes the access in that same cycle, so it drops the stall at once.
  assign mem_stall = !MemReadyM &
                     ((state_q == MEM_WAIT) | ((state_q == MEM_IDLE) & MemReqM & !abort_q));

  assign ldr_stall   = MemtoRegE & valid_e & ((RA1D == wa3_e) | (RA2D == wa3_e));
  assign pc_wr_pend  = PCSrcD | PCSrcE | PCSrcM;
  assign flush_e_int = (ldr_stall | BranchTakenE) & !mem_stall;

  logic hit_1m, hit_1w, hit_2m, hit_2w;
  assign hit_1m = valid_m & valid_e & (ra1_e == wa3_m) & RegWriteM;
  assign hit_1w = valid_w & valid_e & (ra1_e == wa3_w) & RegWriteW;
  assign hit_2m = valid_m & valid_e & (ra2_e == wa3_m) & RegWriteM;
  assign hit_2w = valid_w & valid_e & (ra2_e == wa3_w) & RegWriteW;

  // Outputs are forced quiet while reset is held so the datapath sees no enables or clears.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      StallF    = ldr_stall | pc_wr_pend | mem_stall;
      StallD    = ldr_stall | mem_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushD    = (pc_wr_pend | PCSrcW | BranchTakenE) & !mem_stall;
      FlushE    = flush_e_int;
      FlushW    = mem_stall;
      ForwardAE = fwd_sel(hit_1m, hit_1w);
      ForwardBE = fwd_sel(hit_2m, hit_2w);
    end
  end

  assign MemTimeout = timeout_q;

endmodule
